// File: rtl/dcache_pkg.sv
// Shared types and helpers for the direct-mapped write-through data cache responder.
package dcache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        FILL,
        WTHRU,
        RESP
    } dcache_state_e;

    function automatic int tag_width(input int addr_w, input int index_w);
        return addr_w - index_w - 2;
    endfunction

    function automatic int num_lines(input int index_w);
        return 1 << index_w;
    endfunction

    // Tags are zero-extended to 32 bits by the caller so one function serves any geometry.
    function automatic logic is_hit(input logic valid, input logic [31:0] line_tag,
                                    input logic [31:0] req_tag);
        return valid && (line_tag == req_tag);
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag+data line storage: one synchronous read port, one write port, no reset so it maps to BRAM.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int INDEX_W = 10,
    parameter int TAG_W   = 20,
    parameter int DATA_W  = 32
) (
    input  logic               clk,
    input  logic               rd_en,
    input  logic [INDEX_W-1:0] rd_index,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [DATA_W-1:0]  rd_data,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [DATA_W-1:0]  wr_data
);

    localparam int DEPTH = num_lines(INDEX_W);

    logic [TAG_W+DATA_W-1:0] mem [DEPTH];
    logic [TAG_W+DATA_W-1:0] rd_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_index] <= {wr_tag, wr_data};
        end
        if (rd_en) begin
            rd_q <= mem[rd_index];
        end
    end

    assign {rd_tag, rd_data} = rd_q;

endmodule

// File: rtl/dcache_responder.sv
// Load/store responder for the core with a direct-mapped, one-word-line, write-through cache.
// state  | meaning
// IDLE   | waiting for a load (priority) or store request
// LOOKUP | registered array output available; decide hit or miss
// FILL   | read miss outstanding on the backing memory
// WTHRU  | store being written through to the backing memory
// RESP   | one-cycle RVALID/BVALID pulse; core request lines ignored
module dcache_responder
    import dcache_pkg::*;
#(
    parameter int INDEX_W = 10,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] core_ARADDR,
    input  logic              core_ARVALID,
    output logic [31:0]       core_RDATA,
    output logic              core_RVALID,
    input  logic [ADDR_W-1:0] core_AWADDR,
    input  logic              core_AWVALID,
    input  logic [31:0]       core_WDATA,
    output logic              core_BVALID,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic [31:0]       perf_hits,
    output logic [31:0]       perf_misses
);

    localparam int TAG_W = tag_width(ADDR_W, INDEX_W);
    localparam int LINES = num_lines(INDEX_W);

    dcache_state_e state_q, state_d;

    logic [ADDR_W-1:2] addr_q, addr_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              bvalid_q, bvalid_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic [31:0]       mwdata_q, mwdata_d;
    logic [31:0]       hits_q, hits_d;
    logic [31:0]       misses_q, misses_d;

    logic [LINES-1:0]   valid_q;

    logic               arr_rd_en;
    logic [INDEX_W-1:0] arr_rd_index;
    logic [TAG_W-1:0]   arr_rd_tag;
    logic [31:0]        arr_rd_data;
    logic               arr_we;
    logic [INDEX_W-1:0] arr_wr_index;
    logic [TAG_W-1:0]   arr_wr_tag;
    logic [31:0]        arr_wr_data;

    logic               lookup_hit;
    logic               unused_addr_bits;

    // Byte-lane bits never matter: every access is a full word.
    assign unused_addr_bits = ^{core_ARADDR[1:0], core_AWADDR[1:0]};

    dcache_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W),
        .DATA_W  (32)
    ) u_array (
        .clk      (clk),
        .rd_en    (arr_rd_en),
        .rd_index (arr_rd_index),
        .rd_tag   (arr_rd_tag),
        .rd_data  (arr_rd_data),
        .wr_en    (arr_we && rst),
        .wr_index (arr_wr_index),
        .wr_tag   (arr_wr_tag),
        .wr_data  (arr_wr_data)
    );

    assign lookup_hit = is_hit(valid_q[addr_q[INDEX_W+1:2]], 32'(arr_rd_tag),
                               32'(addr_q[ADDR_W-1:INDEX_W+2]));

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        rdata_d      = rdata_q;
        rvalid_d     = 1'b0;
        bvalid_d     = 1'b0;
        req_d        = req_q;
        we_d         = we_q;
        maddr_d      = maddr_q;
        mwdata_d     = mwdata_q;
        hits_d       = hits_q;
        misses_d     = misses_q;
        arr_rd_en    = 1'b0;
        arr_rd_index = core_ARADDR[INDEX_W+1:2];
        arr_we       = 1'b0;
        arr_wr_index = addr_q[INDEX_W+1:2];
        arr_wr_tag   = addr_q[ADDR_W-1:INDEX_W+2];
        arr_wr_data  = mem_rdata;

        unique case (state_q)
            IDLE: begin
                if (core_ARVALID) begin
                    addr_d    = core_ARADDR[ADDR_W-1:2];
                    arr_rd_en = 1'b1;
                    state_d   = LOOKUP;
                end else if (core_AWVALID) begin
                    // Write-allocate: the line is updated now, before the write-through completes.
                    addr_d       = core_AWADDR[ADDR_W-1:2];
                    arr_we       = 1'b1;
                    arr_wr_index = core_AWADDR[INDEX_W+1:2];
                    arr_wr_tag   = core_AWADDR[ADDR_W-1:INDEX_W+2];
                    arr_wr_data  = core_WDATA;
                    req_d        = 1'b1;
                    we_d         = 1'b1;
                    maddr_d      = {core_AWADDR[ADDR_W-1:2], 2'b00};
                    mwdata_d     = core_WDATA;
                    state_d      = WTHRU;
                end
            end
            LOOKUP: begin
                if (lookup_hit) begin
                    rdata_d  = arr_rd_data;
                    rvalid_d = 1'b1;
                    hits_d   = hits_q + 32'd1;
                    state_d  = RESP;
                end else begin
                    misses_d = misses_q + 32'd1;
                    req_d    = 1'b1;
                    we_d     = 1'b0;
                    maddr_d  = {addr_q, 2'b00};
                    state_d  = FILL;
                end
            end
            FILL: begin
                if (mem_ack) begin
                    req_d    = 1'b0;
                    arr_we   = 1'b1;
                    rdata_d  = mem_rdata;
                    rvalid_d = 1'b1;
                    state_d  = RESP;
                end
            end
            WTHRU: begin
                if (mem_ack) begin
                    req_d    = 1'b0;
                    we_d     = 1'b0;
                    bvalid_d = 1'b1;
                    state_d  = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            bvalid_q <= 1'b0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            maddr_q  <= '0;
            mwdata_q <= '0;
            hits_q   <= '0;
            misses_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            bvalid_q <= bvalid_d;
            req_q    <= req_d;
            we_q     <= we_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
            hits_q   <= hits_d;
            misses_q <= misses_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (arr_we) begin
            valid_q[arr_wr_index] <= 1'b1;
        end
    end

    assign core_RDATA  = rdata_q;
    assign core_RVALID = rvalid_q;
    assign core_BVALID = bvalid_q;
    assign mem_req     = req_q;
    assign mem_we      = we_q;
    assign mem_addr    = maddr_q;
    assign mem_wdata   = mwdata_q;
    assign perf_hits   = hits_q;
    assign perf_misses = misses_q;

endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder: memory model acks after a programmable delay.
module tb_dcache_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] core_ARADDR = '0;
    logic        core_ARVALID = 1'b0;
    logic [31:0] core_RDATA;
    logic        core_RVALID;
    logic [31:0] core_AWADDR = '0;
    logic        core_AWVALID = 1'b0;
    logic [31:0] core_WDATA = '0;
    logic        core_BVALID;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [31:0] perf_hits;
    logic [31:0] perf_misses;

    int n_checks = 0;
    int n_fail   = 0;

    bit          mem_auto   = 1'b1;
    int          ack_delay  = 3;
    int          req_age    = 0;
    logic [31:0] mem_rd_val = '0;
    logic [31:0] ack_addr   = '0;
    logic        ack_we     = 1'b0;
    logic [31:0] ack_wdata  = '0;

    int rv_cnt = 0;
    int bv_cnt = 0;

    dcache_responder #(.INDEX_W(10), .ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .core_ARADDR  (core_ARADDR),
        .core_ARVALID (core_ARVALID),
        .core_RDATA   (core_RDATA),
        .core_RVALID  (core_RVALID),
        .core_AWADDR  (core_AWADDR),
        .core_AWVALID (core_AWVALID),
        .core_WDATA   (core_WDATA),
        .core_BVALID  (core_BVALID),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .perf_hits    (perf_hits),
        .perf_misses  (perf_misses)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (core_RVALID) rv_cnt++;
        if (core_BVALID) bv_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One cycle, observed at the falling edge; also plays the backing memory.
    task automatic tick();
        @(negedge clk);
        if (mem_ack) begin
            mem_ack = 1'b0;
        end else if (mem_auto && mem_req) begin
            req_age++;
            if (req_age >= ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_rd_val;
                ack_addr  = mem_addr;
                ack_we    = mem_we;
                ack_wdata = mem_wdata;
                req_age   = 0;
            end
        end else begin
            req_age = 0;
        end
    endtask

    task automatic do_load(input logic [31:0] addr, input bit hold, input logic [31:0] next_addr,
                           output int lat, output logic [31:0] data, output bit saw_req);
        core_ARADDR  = addr;
        core_ARVALID = 1'b1;
        lat     = 0;
        data    = '0;
        saw_req = 1'b0;
        for (int i = 1; i <= 50; i++) begin
            tick();
            if (mem_req) saw_req = 1'b1;
            if (core_RVALID) begin
                lat  = i;
                data = core_RDATA;
                break;
            end
        end
        if (hold) core_ARADDR = next_addr;
        else      core_ARVALID = 1'b0;
        tick();
        check("rvalid_one_cycle", 32'(core_RVALID), 32'd0);
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [31:0] data, output int lat);
        core_AWADDR  = addr;
        core_WDATA   = data;
        core_AWVALID = 1'b1;
        lat = 0;
        for (int i = 1; i <= 50; i++) begin
            tick();
            if (core_BVALID) begin
                lat = i;
                break;
            end
        end
        core_AWVALID = 1'b0;
        tick();
        check("bvalid_one_cycle", 32'(core_BVALID), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [31:0] data;
        bit          saw_req;
        int          rv_before;
        int          bv_before;

        repeat (3) tick();
        check("rst_rvalid", 32'(core_RVALID), 32'd0);
        check("rst_bvalid", 32'(core_BVALID), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_hits", perf_hits, 32'd0);
        check("rst_misses", perf_misses, 32'd0);
        check("rst_rdata", core_RDATA, 32'd0);
        rst = 1'b1;
        tick();

        // Cold miss: mem_req appears at t+2, ack 3 cycles in, RVALID the cycle after.
        mem_rd_val = 32'hDEADBEEF;
        ack_delay  = 3;
        do_load(32'h100, 1'b0, 32'h0, lat, data, saw_req);
        check("cold_lat", 32'(lat), 32'd5);
        check("cold_data", data, 32'hDEADBEEF);
        check("cold_mem_addr", ack_addr, 32'h100);
        check("cold_mem_we", 32'(ack_we), 32'd0);
        check("cold_misses", perf_misses, 32'd1);
        check("cold_hits", perf_hits, 32'd0);

        mem_rd_val = 32'hFFFFFFFF;
        do_load(32'h100, 1'b0, 32'h0, lat, data, saw_req);
        check("hit_lat", 32'(lat), 32'd2);
        check("hit_data", data, 32'hDEADBEEF);
        check("hit_no_req", 32'(saw_req), 32'd0);
        check("hit_hits", perf_hits, 32'd1);

        ack_delay = 2;
        bv_before = bv_cnt;
        do_store(32'h200, 32'h12345678, lat);
        check("st_lat", 32'(lat), 32'd3);
        check("st_mem_addr", ack_addr, 32'h200);
        check("st_mem_we", 32'(ack_we), 32'd1);
        check("st_mem_wdata", ack_wdata, 32'h12345678);
        check("st_bvalid_count", 32'(bv_cnt - bv_before), 32'd1);
        ack_delay = 3;
        do_load(32'h200, 1'b0, 32'h0, lat, data, saw_req);
        check("st_ld_lat", 32'(lat), 32'd2);
        check("st_ld_data", data, 32'h12345678);
        check("st_ld_no_req", 32'(saw_req), 32'd0);
        check("st_ld_hits", perf_hits, 32'd2);

        // 0x1100 shares index 0x40 with 0x100 and evicts it.
        mem_rd_val = 32'hCAFEF00D;
        do_load(32'h1100, 1'b0, 32'h0, lat, data, saw_req);
        check("conf_lat", 32'(lat), 32'd5);
        check("conf_data", data, 32'hCAFEF00D);
        check("conf_mem_addr", ack_addr, 32'h1100);
        check("conf_misses", perf_misses, 32'd2);
        mem_rd_val = 32'hDEADBEEF;
        do_load(32'h100, 1'b0, 32'h0, lat, data, saw_req);
        check("reload_lat", 32'(lat), 32'd5);
        check("reload_data", data, 32'hDEADBEEF);
        check("reload_misses", perf_misses, 32'd3);

        rv_before  = rv_cnt;
        mem_rd_val = 32'hCAFEF00D;
        do_load(32'h100, 1'b1, 32'h1100, lat, data, saw_req);
        check("b2b_first_lat", 32'(lat), 32'd2);
        check("b2b_first_data", data, 32'hDEADBEEF);
        do_load(32'h1100, 1'b0, 32'h0, lat, data, saw_req);
        check("b2b_second_lat", 32'(lat), 32'd5);
        check("b2b_second_data", data, 32'hCAFEF00D);
        repeat (4) tick();
        check("b2b_pulse_count", 32'(rv_cnt - rv_before), 32'd2);
        check("b2b_hits", perf_hits, 32'd3);
        check("b2b_misses", perf_misses, 32'd4);

        // Load and store together: the load is served, the store is never taken.
        bv_before    = bv_cnt;
        core_AWADDR  = 32'h300;
        core_WDATA   = 32'h00000055;
        core_AWVALID = 1'b1;
        do_load(32'h1100, 1'b0, 32'h0, lat, data, saw_req);
        core_AWVALID = 1'b0;
        check("both_lat", 32'(lat), 32'd2);
        check("both_data", data, 32'hCAFEF00D);
        repeat (3) tick();
        check("both_no_bvalid", 32'(bv_cnt - bv_before), 32'd0);
        mem_rd_val = 32'h33333333;
        do_load(32'h300, 1'b0, 32'h0, lat, data, saw_req);
        check("both_store_skipped_lat", 32'(lat), 32'd5);
        check("both_store_skipped_data", data, 32'h33333333);
        check("both_hits", perf_hits, 32'd4);
        check("both_misses", perf_misses, 32'd5);

        // Reset in the middle of a fill, then a late ack that must be ignored.
        mem_auto     = 1'b0;
        core_ARADDR  = 32'h400;
        core_ARVALID = 1'b1;
        saw_req      = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (mem_req) begin
                saw_req = 1'b1;
                break;
            end
        end
        check("mid_fill_req_seen", 32'(saw_req), 32'd1);
        core_ARVALID = 1'b0;
        rst = 1'b0;
        tick();
        check("mid_rst_mem_req", 32'(mem_req), 32'd0);
        check("mid_rst_rvalid", 32'(core_RVALID), 32'd0);
        rst = 1'b1;
        rv_before = rv_cnt;
        mem_ack   = 1'b1;
        mem_rdata = 32'hBAD0BAD0;
        repeat (4) tick();
        check("late_ack_no_rvalid", 32'(rv_cnt - rv_before), 32'd0);
        check("late_ack_mem_req", 32'(mem_req), 32'd0);
        check("late_ack_hits", perf_hits, 32'd0);
        check("late_ack_misses", perf_misses, 32'd0);
        mem_auto   = 1'b1;
        mem_rd_val = 32'hDEADBEEF;
        do_load(32'h100, 1'b0, 32'h0, lat, data, saw_req);
        check("post_rst_lat", 32'(lat), 32'd5);
        check("post_rst_data", data, 32'hDEADBEEF);
        check("post_rst_misses", perf_misses, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
